// File: rtl/bus_map_pkg.sv
// Shared address map, FSM state encoding and slave-select type for the
// 12-bit-address / 16-bit-data memory-mapped bus.
package bus_map_pkg;

  localparam logic [11:0] MEM_END       = 12'h1ff;
  localparam logic [11:0] KEYPAD_ADDR   = 12'h900;
  localparam logic [11:0] SEVENSEG_ADDR = 12'hb00;
  localparam logic [15:0] UNMAPPED_DATA = 16'hf345;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  typedef enum logic [2:0] {
    SEL_MEM,
    SEL_KPDATA,
    SEL_KPSTAT,
    SEL_SEG,
    SEL_NONE
  } sel_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address-to-slave decode, shared by every bus master.
module bus_addr_decode #(
  parameter int unsigned     AW            = 12,
  parameter logic [AW-1:0]   MEM_END       = bus_map_pkg::MEM_END,
  parameter logic [AW-1:0]   KEYPAD_ADDR   = bus_map_pkg::KEYPAD_ADDR,
  parameter logic [AW-1:0]   SEVENSEG_ADDR = bus_map_pkg::SEVENSEG_ADDR
) (
  input  logic [AW-1:0]     addr,
  output bus_map_pkg::sel_t sel
);
  import bus_map_pkg::*;

  localparam logic [AW-1:0] KeypadStatAddr = KEYPAD_ADDR + {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    sel = SEL_NONE;
    if (addr <= MEM_END)              sel = SEL_MEM;
    else if (addr == KEYPAD_ADDR)     sel = SEL_KPDATA;
    else if (addr == KeypadStatAddr)  sel = SEL_KPSTAT;
    else if (addr == SEVENSEG_ADDR)   sel = SEL_SEG;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter that runs each grant as an IDLE/ACCESS/RESP
// transaction and owns the keypad strobes and the seven-segment register.
module mem_bus_arbiter #(
  parameter int unsigned   AW            = 12,
  parameter int unsigned   DW            = 16,
  parameter logic [AW-1:0] MEM_END       = bus_map_pkg::MEM_END,
  parameter logic [AW-1:0] KEYPAD_ADDR   = bus_map_pkg::KEYPAD_ADDR,
  parameter logic [AW-1:0] SEVENSEG_ADDR = bus_map_pkg::SEVENSEG_ADDR,
  parameter logic [DW-1:0] UNMAPPED_DATA = bus_map_pkg::UNMAPPED_DATA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          kp_ack,
  output logic          kp_statusordata,
  input  logic [DW-1:0] kp_rdata,
  output logic [DW-1:0] seg_data,
  output logic          grant
);
  import bus_map_pkg::*;

  state_t        state_q;
  logic          grant_q;
  logic          ptr_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] seg_q;
  logic [DW-1:0] rd0_q;
  logic [DW-1:0] rd1_q;

  sel_t          sel;
  logic          win;
  logic          in_access;
  logic          in_resp;
  logic [DW-1:0] rd_val;

  bus_addr_decode #(
    .AW           (AW),
    .MEM_END      (MEM_END),
    .KEYPAD_ADDR  (KEYPAD_ADDR),
    .SEVENSEG_ADDR(SEVENSEG_ADDR)
  ) u_decode (
    .addr(addr_q),
    .sel (sel)
  );

  // On contention the master that did not win last time gets the bus.
  always_comb begin
    if (m0_req && m1_req) win = ~ptr_q;
    else                  win = ~m0_req;
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  always_comb begin
    rd_val = UNMAPPED_DATA;
    unique case (sel)
      SEL_MEM:    rd_val = mem_rdata;
      SEL_KPDATA: rd_val = kp_rdata;
      SEL_KPSTAT: rd_val = kp_rdata;
      SEL_SEG:    rd_val = seg_q;
      default:    rd_val = UNMAPPED_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      seg_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q <= ACCESS;
            grant_q <= win;
            ptr_q   <= win;
            addr_q  <= win ? m1_addr  : m0_addr;
            we_q    <= win ? m1_we    : m0_we;
            wdata_q <= win ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (we_q && sel == SEL_SEG) seg_q <= wdata_q;
        end
        RESP: begin
          state_q <= IDLE;
          if (!we_q) begin
            if (grant_q) rd1_q <= rd_val;
            else         rd0_q <= rd_val;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is forwarded combinationally in the ack cycle, then held.
  assign m0_ack   = in_resp && !grant_q;
  assign m1_ack   = in_resp &&  grant_q;
  assign m0_rdata = (m0_ack && !we_q) ? rd_val : rd0_q;
  assign m1_rdata = (m1_ack && !we_q) ? rd_val : rd1_q;

  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_we          = in_access && we_q && (sel == SEL_MEM);
  assign kp_ack          = in_access && !we_q && (sel == SEL_KPDATA);
  assign kp_statusordata = in_access && !we_q && (sel == SEL_KPSTAT);
  assign seg_data        = seg_q;
  assign grant           = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small synchronous RAM model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, kp_rdata, seg_data;
  logic        mem_we, kp_ack, kp_statusordata, grant;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_seg = 16'h0000;
  logic [15:0] ram [4096];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  mem_bus_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req         (m0_req),
    .m0_addr        (m0_addr),
    .m0_we          (m0_we),
    .m0_wdata       (m0_wdata),
    .m0_rdata       (m0_rdata),
    .m0_ack         (m0_ack),
    .m1_req         (m1_req),
    .m1_addr        (m1_addr),
    .m1_we          (m1_we),
    .m1_wdata       (m1_wdata),
    .m1_rdata       (m1_rdata),
    .m1_ack         (m1_ack),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .kp_ack         (kp_ack),
    .kp_statusordata(kp_statusordata),
    .kp_rdata       (kp_rdata),
    .seg_data       (seg_data),
    .grant          (grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a negedge with the DUT in IDLE.
  task automatic txn(input int m, input logic we, input logic [11:0] a, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input logic chk_rd);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
    @(negedge clk);
    chk("access_grant", {31'd0, grant}, m);
    chk("access_acks", {30'd0, m1_ack, m0_ack}, 0);
    chk("access_mem_we", {31'd0, mem_we}, {31'd0, we && (a <= 12'h1ff)});
    chk("access_kp_ack", {31'd0, kp_ack}, {31'd0, !we && (a == 12'h900)});
    chk("access_kp_sod", {31'd0, kp_statusordata}, {31'd0, !we && (a == 12'h901)});
    if (a <= 12'h1ff) chk("access_mem_addr", {20'd0, mem_addr}, {20'd0, a});
    if (we && a == 12'hb00) exp_seg = wd;
    @(negedge clk);
    chk("resp_acks", {30'd0, m1_ack, m0_ack}, (m == 0) ? 1 : 2);
    chk("resp_strobes", {30'd0, mem_we, kp_ack}, 0);
    chk("resp_seg", {16'd0, seg_data}, {16'd0, exp_seg});
    if (chk_rd) chk("resp_rdata", {16'd0, (m == 0) ? m0_rdata : m1_rdata}, {16'd0, exp_rd});
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    chk("idle_acks", {30'd0, m1_ack, m0_ack}, 0);
    if (chk_rd) chk("held_rdata", {16'd0, (m == 0) ? m0_rdata : m1_rdata}, {16'd0, exp_rd});
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    kp_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_outputs", {26'd0, m0_ack, m1_ack, mem_we, kp_ack, kp_statusordata, grant}, 0);
    chk("rst_seg", {16'd0, seg_data}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

    // Both masters request continuously: grants alternate starting with m0.
    m0_req = 1'b1; m0_addr = 12'h010;
    m1_req = 1'b1; m1_addr = 12'h020;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", {31'd0, grant}, k % 2);
      chk("rr_access_acks", {30'd0, m1_ack, m0_ack}, 0);
      @(negedge clk);
      chk("rr_resp_acks", {30'd0, m1_ack, m0_ack}, (k % 2 == 0) ? 1 : 2);
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      @(negedge clk);
      chk("rr_idle_acks", {30'd0, m1_ack, m0_ack}, 0);
    end

    txn(0, 1'b1, 12'h010, 16'h1234, 16'h0000, 1'b0);
    txn(0, 1'b0, 12'h010, 16'h0000, 16'h1234, 1'b1);

    kp_rdata = 16'h0007;
    txn(1, 1'b0, 12'h900, 16'h0000, 16'h0007, 1'b1);
    txn(1, 1'b0, 12'h901, 16'h0000, 16'h0007, 1'b1);
    chk("loser_holds", {16'd0, m0_rdata}, {16'd0, 16'h1234});

    txn(0, 1'b1, 12'hb00, 16'hbeef, 16'h0000, 1'b0);
    txn(0, 1'b0, 12'hb00, 16'h0000, 16'hbeef, 1'b1);

    txn(0, 1'b0, 12'h700, 16'h0000, 16'hf345, 1'b1);
    txn(0, 1'b1, 12'h700, 16'h5555, 16'h0000, 1'b0);
    chk("unmapped_write_seg", {16'd0, seg_data}, {16'd0, 16'hbeef});
    txn(0, 1'b0, 12'h010, 16'h0000, 16'h1234, 1'b1);

    // Reset during ACCESS of a RAM write.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h030; m0_wdata = 16'haaaa;
    @(negedge clk);
    chk("pre_rst_mem_we", {31'd0, mem_we}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
    chk("rst_seg_clear", {16'd0, seg_data}, 0);
    chk("rst_grant", {31'd0, grant}, 0);
    m0_req = 1'b0;
    @(negedge clk);
    chk("rst_hold_acks", {30'd0, m1_ack, m0_ack}, 0);
    rst_n = 1'b1;
    exp_seg = 16'h0000;
    @(negedge clk);
    chk("post_rst_idle", {29'd0, m0_ack, m1_ack, mem_we}, 0);
    txn(0, 1'b0, 12'h010, 16'h0000, 16'h1234, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
